// File: rtl/zled_pkg.sv
// Shared definitions for the front-panel LED driver: command mode encodings,
// channel state enum and channel count.
package zled_pkg;

    localparam int unsigned NUM_CHAN = 4;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PULSE = 2'd3;

    typedef enum logic [2:0] {
        S_OFF,
        S_ON,
        S_BLK_ON,
        S_BLK_OFF,
        S_PULSE
    } chan_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/zled_channel.sv
// One LED channel: pattern FSM with a tick-driven phase counter and a
// remaining-flash count for finite blinks.
module zled_channel
    import zled_pkg::*;
#(
    parameter int unsigned ON_TICKS    = 250,
    parameter int unsigned OFF_TICKS   = 250,
    parameter int unsigned PULSE_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick,
    input  logic       load,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_count,
    output logic       led,
    output logic       busy
);

    localparam int unsigned PW = $clog2(max3(ON_TICKS, OFF_TICKS, PULSE_TICKS) + 1);

    chan_state_t   state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]    remain_q, remain_d;
    logic          timed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_OFF;
            phase_q  <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            remain_q <= remain_d;
        end
    end

    assign timed = (state_q == S_BLK_ON) || (state_q == S_BLK_OFF) || (state_q == S_PULSE);

    // A load overrides any tick on the same edge, so that tick never counts toward the new phase.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        remain_d = remain_q;
        if (load) begin
            phase_d  = '0;
            remain_d = '0;
            case (cmd_mode)
                MODE_ON:    state_d = S_ON;
                MODE_BLINK: begin
                    state_d  = S_BLK_ON;
                    phase_d  = PW'(ON_TICKS);
                    remain_d = cmd_count;
                end
                MODE_PULSE: begin
                    state_d = S_PULSE;
                    phase_d = PW'(PULSE_TICKS);
                end
                default:    state_d = S_OFF;
            endcase
        end else if (tick && timed) begin
            if (phase_q != PW'(1)) begin
                phase_d = phase_q - PW'(1);
            end else begin
                case (state_q)
                    S_BLK_ON: begin
                        state_d = S_BLK_OFF;
                        phase_d = PW'(OFF_TICKS);
                    end
                    S_BLK_OFF: begin
                        if (remain_q == 4'd1) begin
                            state_d  = S_OFF;
                            phase_d  = '0;
                            remain_d = '0;
                        end else begin
                            state_d  = S_BLK_ON;
                            phase_d  = PW'(ON_TICKS);
                            remain_d = (remain_q == 4'd0) ? 4'd0 : remain_q - 4'd1;
                        end
                    end
                    default: begin
                        state_d = S_OFF;
                        phase_d = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        led  = 1'b0;
        busy = 1'b0;
        if (en) begin
            led  = (state_q == S_ON) || (state_q == S_BLK_ON) || (state_q == S_PULSE);
            busy = (state_q == S_PULSE) ||
                   (((state_q == S_BLK_ON) || (state_q == S_BLK_OFF)) && (remain_q != 4'd0));
        end
    end

endmodule

// File: rtl/zled_driver.sv
// Four-channel front-panel LED driver: shared tick prescaler, command
// decode into per-channel load strobes, and the channel instances.
module zled_driver
    import zled_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned ON_TICKS    = 250,
    parameter int unsigned OFF_TICKS   = 250,
    parameter int unsigned PULSE_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_chan,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_count,
    output logic [3:0] oLed,
    output logic [3:0] busy
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0]    pre_q;
    logic                tick;
    logic                accept;
    logic [NUM_CHAN-1:0] load;

    assign tick      = en && (pre_q == PRE_W'(TICK_DIV - 1));
    assign cmd_ready = en && !rst;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else if (en) begin
            pre_q <= tick ? '0 : pre_q + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        assign load[i] = accept && (cmd_chan == 2'(i));

        zled_channel #(
            .ON_TICKS    (ON_TICKS),
            .OFF_TICKS   (OFF_TICKS),
            .PULSE_TICKS (PULSE_TICKS)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .tick      (tick),
            .load      (load[i]),
            .cmd_mode  (cmd_mode),
            .cmd_count (cmd_count),
            .led       (oLed[i]),
            .busy      (busy[i])
        );
    end

endmodule

// File: tb/tb_zled_driver.sv
// Directed bench for zled_driver with small timing parameters; expected
// waveforms are derived from a bench-side prescaler phase model.
module tb_zled_driver;

    localparam int unsigned TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_chan = 2'd0;
    logic [1:0] cmd_mode = 2'd0;
    logic [3:0] cmd_count = 4'd0;
    logic [3:0] oLed;
    logic [3:0] busy;

    int nvec = 0;
    int nerr = 0;
    int pre = 0;

    zled_driver #(
        .TICK_DIV    (TD),
        .ON_TICKS    (3),
        .OFF_TICKS   (2),
        .PULSE_TICKS (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_chan  (cmd_chan),
        .cmd_mode  (cmd_mode),
        .cmd_count (cmd_count),
        .oLed      (oLed),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // pre mirrors the prescaler value that the next edge will see.
    task automatic cyc();
        @(posedge clk);
        if (rst) pre = 0;
        else if (en) pre = (pre == int'(TD) - 1) ? 0 : pre + 1;
        #1;
    endtask

    task automatic wait_pre(input int v);
        for (int k = 0; k < 8 && pre != v; k++) cyc();
    endtask

    task automatic drive(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] cnt);
        cmd_valid = 1'b1;
        cmd_chan  = ch;
        cmd_mode  = mode;
        cmd_count = cnt;
    endtask

    task automatic issue(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] cnt);
        drive(ch, mode, cnt);
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        int rises;
        logic prev;
        logic [3:0] el, eb;

        // Reset with a command pending
        rst = 1'b1; en = 1'b1;
        drive(2'd0, 2'd1, 4'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rst_led", oLed, 4'b0000);
            chk("rst_busy", busy, 4'b0000);
            chk("rst_ready", {3'b000, cmd_ready}, 4'b0000);
        end
        rst = 1'b0; cmd_valid = 1'b0;
        #1;
        chk("ready_after_rst", {3'b000, cmd_ready}, 4'b0001);

        // ON then OFF on channel 2
        issue(2'd2, 2'd1, 4'd0);
        chk("on2_led", oLed, 4'b0100);
        chk("on2_busy", busy, 4'b0000);
        for (int k = 0; k < 5; k++) cyc();
        chk("on2_hold", oLed, 4'b0100);
        issue(2'd2, 2'd0, 4'd0);
        chk("off2_led", oLed, 4'b0000);
        chk("off2_busy", busy, 4'b0000);

        // BLINK count=2 on channel 0; accepted at edge E with ticks at E+3, E+7, ...
        wait_pre(0);
        rises = 0; prev = 1'b0;
        for (int i = 0; i <= 44; i++) begin
            if (i == 0) issue(2'd0, 2'd2, 4'd2);
            else cyc();
            el = {3'b000, (i < 11) || (i >= 19 && i < 31)};
            eb = {3'b000, i < 39};
            chk("blink0_led", oLed, el);
            chk("blink0_busy", busy, eb);
            if (oLed[0] && !prev) rises++;
            prev = oLed[0];
        end
        chk("blink0_rises", 4'(rises), 4'd2);

        // PULSE on channel 3, OFF six cycles later
        issue(2'd3, 2'd3, 4'd0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc();
            chk("pulse3_led", oLed, 4'b1000);
            chk("pulse3_busy", busy, 4'b1000);
        end
        issue(2'd3, 2'd0, 4'd0);
        chk("pulse3_off_led", oLed, 4'b0000);
        chk("pulse3_off_busy", busy, 4'b0000);

        // Continuous BLINK on channel 1 with a 10-cycle enable gap
        wait_pre(0);
        for (int i = 0; i <= 5; i++) begin
            if (i == 0) issue(2'd1, 2'd2, 4'd0);
            else cyc();
            chk("cblink_pre_led", oLed, 4'b0010);
            chk("cblink_pre_busy", busy, 4'b0000);
        end
        en = 1'b0;
        for (int w = 0; w < 10; w++) begin
            #1;
            chk("dis_led", oLed, 4'b0000);
            chk("dis_busy", busy, 4'b0000);
            chk("dis_ready", {3'b000, cmd_ready}, 4'b0000);
            cyc();
        end
        en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            el = {2'b00, (5 + k < 11) || (5 + k >= 19), 1'b0};
            chk("cblink_resume_led", oLed, el);
            chk("cblink_resume_busy", busy, 4'b0000);
        end
        issue(2'd1, 2'd0, 4'd0);
        chk("cblink_off", oLed, 4'b0000);

        // Four channels at once; channel 0 re-commanded on its phase-ending tick (E+11)
        wait_pre(0);
        for (int i = 0; i <= 35; i++) begin
            case (i)
                0:       drive(2'd0, 2'd2, 4'd0);
                1:       drive(2'd1, 2'd3, 4'd0);
                2:       drive(2'd2, 2'd1, 4'd0);
                3:       drive(2'd3, 2'd2, 4'd1);
                11:      drive(2'd0, 2'd3, 4'd0);
                default: cmd_valid = 1'b0;
            endcase
            cyc();
            cmd_valid = 1'b0;
            el = {(i >= 3 && i < 15), (i >= 2), (i >= 1 && i < 19), (i < 31)};
            eb = {(i >= 3 && i < 23), 1'b0, (i >= 1 && i < 19), (i >= 11 && i < 31)};
            chk("multi_led", oLed, el);
            chk("multi_busy", busy, eb);
        end

        // Back-to-back commands to one channel: last wins
        drive(2'd1, 2'd1, 4'd0);
        cyc();
        drive(2'd1, 2'd0, 4'd0);
        cyc();
        cmd_valid = 1'b0;
        chk("b2b_led", oLed, 4'b0100);

        // Reset mid-pattern
        issue(2'd0, 2'd2, 4'd0);
        issue(2'd3, 2'd3, 4'd0);
        chk("pre_rst_led", oLed, 4'b1101);
        rst = 1'b1;
        cyc();
        chk("midrst_led", oLed, 4'b0000);
        chk("midrst_busy", busy, 4'b0000);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) cyc();
        chk("post_rst_led", oLed, 4'b0000);
        chk("post_rst_ready", {3'b000, cmd_ready}, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
